// File: rtl/lanzones_mem_pkg.sv
// lanzones_mem_pkg: shared FSM state type, port indices and default widths
// for the lanzones memory arbiter.
package lanzones_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  localparam logic PORT_IF = 1'b0;  // instruction fetch
  localparam logic PORT_LS = 1'b1;  // load/store

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/lanzones_arb2.sv
// lanzones_arb2: two-way winner select for the lanzones memory arbiter.
// Build option ARB_ROUNDROBIN_EN: adds a 1-bit round-robin pointer;
// without it port 1 (load/store) has fixed priority.
module lanzones_arb2
  import lanzones_mem_pkg::*;
(
`ifdef ARB_ROUNDROBIN_EN
  input  logic clk_i,
  input  logic rstn_i,
  input  logic take_i,
`endif
  input  logic req0_i,
  input  logic req1_i,
  output logic any_o,
  output logic win_o
);

  assign any_o = req0_i | req1_i;

`ifdef ARB_ROUNDROBIN_EN
  logic prio_q;  // port that wins the next contention

  // Winner is the pointer on contention, otherwise the sole requester.
  always_comb begin
    if (req0_i && req1_i) begin
      win_o = prio_q;
    end else if (req1_i) begin
      win_o = PORT_LS;
    end else begin
      win_o = PORT_IF;
    end
  end

  // After each grant, priority moves to the port that was not served.
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      prio_q <= PORT_IF;
    end else if (take_i) begin
      prio_q <= ~win_o;
    end
  end
`else
  // Load/store port wins whenever it is requesting.
  always_comb begin
    win_o = req1_i ? PORT_LS : PORT_IF;
  end
`endif

endmodule

// File: rtl/lanzones_mem_arbiter.sv
// lanzones_mem_arbiter: shares the single lanzones memory port between the
// instruction-fetch (m0) and load/store (m1) requesters, one transaction at
// a time. Build option ARB_ROUNDROBIN_EN selects round-robin arbitration.
module lanzones_mem_arbiter
  import lanzones_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_strb,
  output logic                  m0_gnt,
  output logic                  m0_vld,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_strb,
  output logic                  m1_gnt,
  output logic                  m1_vld,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  mem_rrdy,
  input  logic                  mem_rvld,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     mem_raddr,
  output logic [DATA_W-1:0]     mem_rwdata,
  output logic                  mem_rwen,
  output logic [DATA_W/8-1:0]   mem_rwstrobe,
  output logic                  busy
);

  state_e                state_q;
  logic                  owner_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   strb_q;

  logic                  any_req;
  logic                  win;
  logic                  grant;
  logic                  sel_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [DATA_W/8-1:0]   sel_strb;

  lanzones_arb2 u_arb (
`ifdef ARB_ROUNDROBIN_EN
    .clk_i  (clk),
    .rstn_i (rstn),
    .take_i (grant),
`endif
    .req0_i (m0_req),
    .req1_i (m1_req),
    .any_o  (any_req),
    .win_o  (win)
  );

  // Grant is masked while reset is held so every output reads 0 in reset.
  assign grant = (state_q == IDLE) && any_req && !rstn;

  // Payload of the winning requester, captured on grant.
  always_comb begin
    if (win == PORT_LS) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_strb  = m1_strb;
    end else begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_strb  = m0_strb;
    end
  end

  // Transaction FSM with payload capture; the state itself records read/write.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      owner_q <= PORT_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q <= win;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            strb_q  <= sel_strb;
            state_q <= sel_we ? WR : RD;
          end
        end
        RD: begin
          if (mem_rvld) begin
            state_q <= IDLE;
          end
        end
        WR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Requester and memory-side outputs decoded from state and captured payload.
  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    m0_vld       = 1'b0;
    m1_vld       = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    mem_rrdy     = 1'b0;
    mem_raddr    = '0;
    mem_rwdata   = '0;
    mem_rwen     = 1'b0;
    mem_rwstrobe = '0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          if (win == PORT_LS) begin
            m1_gnt = 1'b1;
          end else begin
            m0_gnt = 1'b1;
          end
        end
      end
      RD: begin
        // Dropping rrdy as soon as rvld is seen prevents a second read.
        mem_rrdy  = !mem_rvld;
        mem_raddr = addr_q;
        if (mem_rvld) begin
          if (owner_q == PORT_LS) begin
            m1_vld   = 1'b1;
            m1_rdata = mem_rdata;
          end else begin
            m0_vld   = 1'b1;
            m0_rdata = mem_rdata;
          end
        end
      end
      WR: begin
        mem_rwen     = 1'b1;
        mem_raddr    = addr_q;
        mem_rwdata   = wdata_q;
        mem_rwstrobe = strb_q;
        if (owner_q == PORT_LS) begin
          m1_vld = 1'b1;
        end else begin
          m0_vld = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_lanzones_mem_arbiter.sv
// tb_lanzones_mem_arbiter: directed and randomized checks of the lanzones
// memory arbiter against a transaction-level reference model.
module tb_lanzones_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

`ifdef ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [SW-1:0] m0_strb = '0;
  logic          m0_gnt, m0_vld;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [SW-1:0] m1_strb = '0;
  logic          m1_gnt, m1_vld;
  logic [DW-1:0] m1_rdata;
  logic          mem_rrdy, mem_rvld, mem_rwen, busy;
  logic [DW-1:0] mem_rdata, mem_rwdata;
  logic [AW-1:0] mem_raddr;
  logic [SW-1:0] mem_rwstrobe;

  int n_cmp = 0;
  int n_err = 0;

  lanzones_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_strb(m0_strb), .m0_gnt(m0_gnt), .m0_vld(m0_vld), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_strb(m1_strb), .m1_gnt(m1_gnt), .m1_vld(m1_vld), .m1_rdata(m1_rdata),
    .mem_rrdy(mem_rrdy), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
    .mem_raddr(mem_raddr), .mem_rwdata(mem_rwdata), .mem_rwen(mem_rwen),
    .mem_rwstrobe(mem_rwstrobe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: registered (rvld one cycle after rrdy) or zero-wait.
  logic [DW-1:0] mem [0:1023];
  logic          zw = 1'b0;
  logic          rvld_q = 1'b0;
  logic [DW-1:0] rdq = '0;
  logic          pl_en = 1'b0;
  logic [9:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_rwen) begin
      for (int b = 0; b < SW; b++) begin
        if (mem_rwstrobe[b]) mem[mem_raddr[9:0]][8*b +: 8] <= mem_rwdata[8*b +: 8];
      end
    end
    rvld_q <= mem_rrdy;
    if (mem_rrdy) rdq <= mem[mem_raddr[9:0]];
  end

  assign mem_rvld  = zw ? 1'b1 : rvld_q;
  assign mem_rdata = zw ? mem[mem_raddr[9:0]] : rdq;

  task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_strb = '1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = $urandom;
    @(posedge clk); #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_vld, m1_vld, busy, mem_rrdy, mem_rwen} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {m0_gnt, m1_gnt, m0_vld, m1_vld, busy, mem_rrdy, mem_rwen});
    end
    n_cmp++;
    if ({m0_rdata, m1_rdata, mem_raddr, mem_rwdata, mem_rwstrobe} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h/%h/%h/%h required all 0",
               m0_rdata, m1_rdata, mem_raddr, mem_rwdata, mem_rwstrobe);
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; rstn = 1'b0;
    #1;
    n_cmp++;
    if ({busy, m0_gnt, m1_gnt} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got %b required 000", {busy, m0_gnt, m1_gnt});
    end
  endtask

  task automatic test_read();
    zw = 1'b0;
    preload(10'h100, 32'h0000_0013);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = $urandom; m0_strb = '1;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_err++; $display("FAIL read_gnt: got %b required 10", {m0_gnt, m1_gnt});
    end
    @(negedge clk);
    m0_req = 1'b0; m0_addr = $urandom;
    #1;
    n_cmp++;
    if (mem_rrdy !== 1'b1 || mem_raddr !== 32'h100 || m0_vld !== 1'b0 || m1_vld !== 1'b0) begin
      n_err++;
      $display("FAIL read_rrdy: got rrdy=%b raddr=%h vld=%b%b required rrdy=1 raddr=00000100 vld=00",
               mem_rrdy, mem_raddr, m0_vld, m1_vld);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (m0_vld !== 1'b1 || m0_rdata !== 32'h13 || m1_vld !== 1'b0 || mem_rrdy !== 1'b0) begin
      n_err++;
      $display("FAIL read_data: got vld=%b rdata=%h m1_vld=%b rrdy=%b required 1 00000013 0 0",
               m0_vld, m0_rdata, m1_vld, mem_rrdy);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({busy, m0_vld, m1_vld} !== 3'b0) begin
      n_err++; $display("FAIL read_done: got %b required 000", {busy, m0_vld, m1_vld});
    end
  endtask

  task automatic test_write();
    preload(10'h010, 32'h1122_3344);
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h010; m1_wdata = 32'hAABB_CCDD; m1_strb = 4'b0011;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_err++; $display("FAIL write_gnt: got %b required 01", {m0_gnt, m1_gnt});
    end
    @(negedge clk);
    m1_req = 1'b0; m1_addr = $urandom; m1_wdata = $urandom; m1_strb = $urandom;
    #1;
    n_cmp++;
    if (mem_rwen !== 1'b1 || mem_raddr !== 32'h010 || mem_rwdata !== 32'hAABB_CCDD ||
        mem_rwstrobe !== 4'b0011) begin
      n_err++;
      $display("FAIL write_mem: got wen=%b addr=%h data=%h strb=%b required 1 00000010 aabbccdd 0011",
               mem_rwen, mem_raddr, mem_rwdata, mem_rwstrobe);
    end
    n_cmp++;
    if (m1_vld !== 1'b1 || m1_rdata !== '0 || m0_vld !== 1'b0) begin
      n_err++;
      $display("FAIL write_vld: got m1_vld=%b rdata=%h m0_vld=%b required 1 00000000 0",
               m1_vld, m1_rdata, m0_vld);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (mem_rwen !== 1'b0 || mem[10'h010] !== 32'h1122_CCDD) begin
      n_err++;
      $display("FAIL write_result: got wen=%b mem=%h required 0 1122ccdd", mem_rwen, mem[10'h010]);
    end
  endtask

  task automatic test_contention();
    int  got = 0;
    logic exp_w;
    apply_reset();
    m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = $urandom; m0_strb = '1;
    m1_we = 1'b1; m1_addr = 32'h31; m1_wdata = $urandom; m1_strb = '1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      m0_req = 1'b1; m1_req = 1'b1;
      #1;
      if (m0_gnt || m1_gnt) begin
        exp_w = RR ? ((got % 2) == 1) : 1'b1;
        n_cmp++;
        if ({m0_gnt, m1_gnt} !== (exp_w ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL contention_grant%0d: got %b required %b", got, {m0_gnt, m1_gnt},
                   exp_w ? 2'b01 : 2'b10);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_err++; $display("FAIL contention_count: got %0d grants required 4", got);
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero_wait();
    zw = 1'b1;
    preload(10'h001, 32'h5);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_err++; $display("FAIL zw_gnt: got %b required 10", {m0_gnt, m1_gnt});
    end
    @(negedge clk);
    m0_req = 1'b0; m0_addr = $urandom;
    #1;
    n_cmp++;
    if (m0_vld !== 1'b1 || m0_rdata !== 32'h5 || busy !== 1'b1 || mem_rrdy !== 1'b0) begin
      n_err++;
      $display("FAIL zw_vld: got vld=%b rdata=%h busy=%b rrdy=%b required 1 00000005 1 0",
               m0_vld, m0_rdata, busy, mem_rrdy);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || m0_vld !== 1'b0) begin
      n_err++; $display("FAIL zw_idle: got busy=%b vld=%b required 0 0", busy, m0_vld);
    end
    zw = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d4 = $urandom;
    zw = 1'b0;
    preload(10'h100, 32'h13);
    preload(10'h004, d4);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    #1;
    n_cmp++;
    if (m0_gnt !== 1'b1) begin
      n_err++; $display("FAIL rstmid_gnt: got %b required 1", m0_gnt);
    end
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    n_cmp++;
    if (mem_rrdy !== 1'b1) begin
      n_err++; $display("FAIL rstmid_rd: got rrdy=%b required 1", mem_rrdy);
    end
    #1;
    rstn = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_vld, m1_vld, busy, mem_rrdy, mem_rwen} !== 7'b0 ||
        {m0_rdata, m1_rdata, mem_raddr, mem_rwdata, mem_rwstrobe} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got ctrl=%b raddr=%h required all 0",
               {m0_gnt, m1_gnt, m0_vld, m1_vld, busy, mem_rrdy, mem_rwen}, mem_raddr);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_vld} !== 3'b010) begin
      n_err++; $display("FAIL rstmid_first_gnt: got %b required 010", {m0_gnt, m1_gnt, m0_vld});
    end
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    n_cmp++;
    if (m0_vld !== 1'b0 || m1_vld !== 1'b0) begin
      n_err++; $display("FAIL rstmid_no_vld: got %b%b required 00", m0_vld, m1_vld);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (m0_vld !== 1'b0 || m1_vld !== 1'b1 || m1_rdata !== d4) begin
      n_err++;
      $display("FAIL rstmid_after: got m0_vld=%b m1_vld=%b rdata=%h required 0 1 %h",
               m0_vld, m1_vld, m1_rdata, d4);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a = $urandom;
    logic [DW-1:0] b = $urandom;
    logic [DW-1:0] d1 = '0, d2 = '0;
    int g1 = -1, g2 = -1, v1 = -1, v2 = -1, ng = 0, nv = 0;
    zw = 1'b0;
    preload(10'h000, a);
    preload(10'h004, b);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      m1_req = (ng < 2); m1_we = 1'b0; m1_addr = (ng == 0) ? 32'h0 : 32'h4;
      #1;
      if (m1_gnt) begin
        if (ng == 0) g1 = c; else g2 = c;
        ng++;
      end
      if (m1_vld) begin
        if (nv == 0) begin v1 = c; d1 = m1_rdata; end
        else begin v2 = c; d2 = m1_rdata; end
        nv++;
      end
    end
    m1_req = 1'b0;
    n_cmp++;
    if (g1 < 0 || g2 - g1 != 3) begin
      n_err++; $display("FAIL b2b_gap: got gnts at %0d,%0d required spacing 3", g1, g2);
    end
    n_cmp++;
    if (v1 != g1 + 2 || d1 !== a) begin
      n_err++; $display("FAIL b2b_first: got vld@%0d data=%h required @%0d %h", v1, d1, g1 + 2, a);
    end
    n_cmp++;
    if (v2 != g2 + 2 || d2 !== b || nv != 2) begin
      n_err++;
      $display("FAIL b2b_second: got vld@%0d data=%h count=%0d required @%0d %h 2",
               v2, d2, nv, g2 + 2, b);
    end
  endtask

  // Transaction-level model: at most one outstanding, fixed latency per kind.
  task automatic test_random(input logic zwait);
    logic [DW-1:0] refm [0:15];
    logic          act [2];
    logic          rwe [2];
    logic [AW-1:0] radr [2];
    logic [DW-1:0] rwd [2];
    logic [SW-1:0] rst [2];
    logic          ost = 1'b0, ost_port = 1'b0, last = 1'b1, w;
    logic [DW-1:0] ost_rd = '0;
    int            due = 0, free_at = 0;
    logic          ev0, ev1, eany;
    logic [DW-1:0] er0, er1;
    zw = zwait;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      refm[i] = $urandom;
      preload(10'(i), refm[i]);
    end
    for (int p = 0; p < 2; p++) act[p] = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && cyc < 280 && $urandom_range(0, 99) < 50) begin
          act[p] = 1'b1;
          rwe[p] = 1'($urandom_range(0, 1));
          radr[p] = AW'($urandom_range(0, 15));
          rwd[p] = $urandom;
          rst[p] = SW'($urandom);
        end else if (!act[p]) begin
          rwe[p] = 1'($urandom_range(0, 1));
          radr[p] = $urandom;
          rwd[p] = $urandom;
          rst[p] = SW'($urandom);
        end
      end
      m0_req = act[0]; m0_we = rwe[0]; m0_addr = radr[0]; m0_wdata = rwd[0]; m0_strb = rst[0];
      m1_req = act[1]; m1_we = rwe[1]; m1_addr = radr[1]; m1_wdata = rwd[1]; m1_strb = rst[1];
      #1;
      ev0 = ost && due == cyc && !ost_port;
      ev1 = ost && due == cyc && ost_port;
      er0 = ev0 ? ost_rd : '0;
      er1 = ev1 ? ost_rd : '0;
      n_cmp++;
      if (m0_vld !== ev0 || m0_rdata !== er0) begin
        n_err++;
        $display("FAIL rnd_vld0 cyc=%0d: got %b %h required %b %h", cyc, m0_vld, m0_rdata, ev0, er0);
      end
      n_cmp++;
      if (m1_vld !== ev1 || m1_rdata !== er1) begin
        n_err++;
        $display("FAIL rnd_vld1 cyc=%0d: got %b %h required %b %h", cyc, m1_vld, m1_rdata, ev1, er1);
      end
      if (ost && due == cyc) begin
        ost = 1'b0;
        free_at = cyc + 1;
      end
      eany = (act[0] || act[1]) && !ost && cyc >= free_at;
      w = (act[0] && act[1]) ? (RR ? !last : 1'b1) : act[1];
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== {eany && !w, eany && w}) begin
        n_err++;
        $display("FAIL rnd_gnt cyc=%0d: got %b required %b", cyc, {m0_gnt, m1_gnt},
                 {eany && !w, eany && w});
      end
      if (eany) begin
        ost = 1'b1;
        ost_port = w;
        last = w;
        due = cyc + ((rwe[w] || zwait) ? 1 : 2);
        if (rwe[w]) begin
          for (int b = 0; b < SW; b++) begin
            if (rst[w][b]) refm[radr[w][3:0]][8*b +: 8] = rwd[w][8*b +: 8];
          end
          ost_rd = '0;
        end else begin
          ost_rd = refm[radr[w][3:0]];
        end
        act[w] = 1'b0;
      end
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
    zw = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_zero_wait();
    test_reset_mid();
    test_back_to_back();
    test_random(1'b0);
    test_random(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
